// File: rtl/miner_pkg.sv
// Shared widths, sequencer state type and the golden-target test for the
// SHA-256 double-hash miner control path.
package miner_pkg;
   localparam int NONCE_W = 32;
   localparam int HASH_W  = 256;
   localparam int CNT_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   // A second-stage digest is golden when its most significant word is zero.
   function automatic logic is_golden(input logic [NONCE_W-1:0] top_word);
      return top_word == '0;
   endfunction
endpackage

// File: rtl/slot_valid_pipe.sv
// Bit shift register marking which nonce slots in the transform pipeline hold
// real work; advances once per slot boundary.
module slot_valid_pipe #(
   parameter int DEPTH = 33
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic bit_i,
   output logic bit_o,
   output logic empty_o
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (en_i) sr_d = (sr_q << 1) | DEPTH'(bit_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) sr_q <= '0;
      else          sr_q <= sr_d;
   end

   assign bit_o   = sr_q[DEPTH-1];
   // Reflects the contents after this cycle's shift, so draining can end on
   // the same edge the last valid slot leaves.
   assign empty_o = (sr_d == '0);

endmodule

// File: rtl/miner_sequencer.sv
// Round sequencing, nonce issue and golden-nonce capture for a folded SHA-256
// double-hash datapath.
module miner_sequencer
   import miner_pkg::*;
#(
   parameter int LOOP      = 4,
   parameter int NONCE_LAG = 33
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [NONCE_W-1:0] nonce_first,
   input  logic [NONCE_W-1:0] nonce_last,
   input  logic [HASH_W-1:0]  hash2_in,
   output logic [CNT_W-1:0]   cnt,
   output logic               feedback,
   output logic [NONCE_W-1:0] nonce,
   output logic               busy,
   output logic               done,
   output logic               golden_valid,
   input  logic               golden_ready,
   output logic [NONCE_W-1:0] golden_nonce,
   output logic               golden_lost
);

   seq_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NONCE_W-1:0] nonce_q, last_q, tail_q, gold_q;
   logic               busy_q, done_q, hold_q, gvalid_q, glost_q;
   logic               boundary, issue, pipe_out, pipe_empty, exit_one, hit, accept;
   logic               hash_low_unused;

   always_comb begin
      cnt_d    = (cnt_q == CNT_W'(LOOP - 1)) ? '0 : cnt_q + CNT_W'(1);
      boundary = (cnt_q == '0);
      issue    = boundary && (state_q == ST_RUN) && !hold_q;
      exit_one = boundary && pipe_out;
      hit      = exit_one && is_golden(hash2_in[HASH_W-1 -: NONCE_W]);
      accept   = gvalid_q && golden_ready;
   end

   // Only the top word decides a golden result; the rest of the digest is ignored.
   assign hash_low_unused = ^hash2_in[HASH_W-NONCE_W-1:0];

   slot_valid_pipe #(
      .DEPTH(NONCE_LAG)
   ) u_pipe (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .en_i   (boundary),
      .bit_i  (issue),
      .bit_o  (pipe_out),
      .empty_o(pipe_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         nonce_q  <= '0;
         last_q   <= '0;
         tail_q   <= '0;
         gold_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hold_q   <= 1'b0;
         gvalid_q <= 1'b0;
         glost_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         // The tail counter names the nonce whose hash is emerging right now.
         if (exit_one) tail_q <= tail_q + NONCE_W'(1);
         if (hit) begin
            if (!gvalid_q || golden_ready) begin
               gold_q   <= tail_q;
               gvalid_q <= 1'b1;
            end else begin
               glost_q  <= 1'b1;
            end
         end else if (accept) begin
            gvalid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  nonce_q <= nonce_first;
                  last_q  <= nonce_last;
                  tail_q  <= nonce_first;
                  glost_q <= 1'b0;
                  hold_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               // An abort between boundaries suppresses the next issue entirely.
               if (!boundary) begin
                  if (abort) hold_q <= 1'b1;
               end else if (hold_q || abort || nonce_q == last_q) begin
                  state_q <= ST_DRAIN;
                  hold_q  <= 1'b0;
               end else begin
                  nonce_q <= nonce_q + NONCE_W'(1);
               end
            end
            ST_DRAIN: begin
               if (pipe_empty) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cnt          = cnt_q;
   assign feedback     = (cnt_q != '0);
   assign nonce        = nonce_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign golden_valid = gvalid_q;
   assign golden_nonce = gold_q;
   assign golden_lost  = glost_q;

endmodule

// File: tb/tb_miner_sequencer.sv
// Self-checking bench for miner_sequencer: reset/slot-counter table, directed
// multi-cycle scenarios and a randomized run against a queue-based model.
module tb_miner_sequencer;
   localparam int LOOP = 4;
   localparam int LAG  = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [31:0]   nonce_first;
   logic [31:0]   nonce_last;
   logic [255:0]  hash2_in;
   logic [5:0]    cnt;
   logic          feedback;
   logic [31:0]   nonce;
   logic          busy;
   logic          done;
   logic          golden_valid;
   logic          golden_ready;
   logic [31:0]   golden_nonce;
   logic          golden_lost;

   miner_sequencer #(.LOOP(LOOP), .NONCE_LAG(LAG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .nonce_first(nonce_first), .nonce_last(nonce_last), .hash2_in(hash2_in),
      .cnt(cnt), .feedback(feedback), .nonce(nonce), .busy(busy), .done(done),
      .golden_valid(golden_valid), .golden_ready(golden_ready),
      .golden_nonce(golden_nonce), .golden_lost(golden_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
   bit          m_ok = 1'b0;
   longint      m_cycle;
   int          m_mode;
   logic [31:0] m_next, m_last, m_gn;
   logic        m_pend, m_gv, m_gl;
   logic        m_slot_v[$];
   logic [31:0] m_slot_n[$];

   always @(posedge clk) begin
      logic ov, og, bnd, allz, pv;
      logic [31:0] on, pn;
      int om;
      if (!rst_n) begin
         m_cycle = 0; m_mode = M_IDLE; m_next = 0; m_last = 0; m_pend = 0;
         m_gv = 0; m_gn = 0; m_gl = 0;
         m_slot_v.delete(); m_slot_n.delete();
         for (int i = 0; i < LAG; i++) begin
            m_slot_v.push_back(1'b0); m_slot_n.push_back(32'd0);
         end
         m_ok = 1'b1;
      end else if (m_ok) begin
         om  = m_mode;
         og  = m_gv;
         bnd = ((m_cycle % LOOP) == 0);
         if (og && golden_ready) m_gv = 1'b0;
         if (bnd) begin
            ov = m_slot_v.pop_front();
            on = m_slot_n.pop_front();
            if (ov && hash2_in[255:224] == 32'd0) begin
               if (!og || golden_ready) begin m_gv = 1'b1; m_gn = on; end
               else m_gl = 1'b1;
            end
            pv = 1'b0; pn = 32'd0;
            if (om == M_RUN) begin
               if (m_pend) m_mode = M_DRAIN;
               else begin
                  pv = 1'b1; pn = m_next;
                  if (m_next == m_last || abort) m_mode = M_DRAIN;
                  else m_next = m_next + 32'd1;
               end
            end
            m_slot_v.push_back(pv);
            m_slot_n.push_back(pn);
         end else if (om == M_RUN && abort) begin
            m_pend = 1'b1;
         end
         if ((om == M_IDLE || om == M_DONE) && start) begin
            m_mode = M_RUN; m_next = nonce_first; m_last = nonce_last;
            m_gl = 1'b0; m_pend = 1'b0;
         end
         if (om == M_DRAIN) begin
            allz = 1'b1;
            foreach (m_slot_v[i]) if (m_slot_v[i]) allz = 1'b0;
            if (allz) m_mode = M_DONE;
         end
         if (m_mode != M_RUN) m_pend = 1'b0;
         m_cycle++;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_cnt",      32'(cnt),          32'(m_cycle % LOOP));
         chk("m_feedback", 32'(feedback),     32'((m_cycle % LOOP) != 0));
         chk("m_nonce",    nonce,             m_next);
         chk("m_busy",     32'(busy),         32'(m_mode == M_RUN || m_mode == M_DRAIN));
         chk("m_done",     32'(done),         32'(m_mode == M_DONE));
         chk("m_gvalid",   32'(golden_valid), 32'(m_gv));
         chk("m_gnonce",   golden_nonce,      m_gn);
         chk("m_glost",    32'(golden_lost),  32'(m_gl));
      end
   end

   // ---------------- stimulus helpers ----------------
   int          policy = 0;   // 0 never golden, 1 always, 2 only for target, 3 random
   logic [31:0] target = 0;

   task automatic cyc();
      logic [31:0] top;
      @(posedge clk);
      #1;
      case (policy)
         1:       top = 32'd0;
         2:       top = (m_slot_v.size() > 0 && m_slot_v[0] && m_slot_n[0] == target)
                        ? 32'd0 : 32'h1234_5678;
         3:       top = ($urandom_range(0, 9) < 4) ? 32'd0 : (32'h8000_0000 | $urandom());
         default: top = 32'hDEAD_BEEF;
      endcase
      hash2_in = {top, {7{$urandom()}}};
   endtask

   task automatic align();
      for (int i = 0; i < LOOP && cnt != 6'd0; i++) cyc();
      chk("align_cnt", 32'(cnt), 32'd0);
   endtask

   task automatic go(input logic [31:0] f, input logic [31:0] l);
      nonce_first = f; nonce_last = l; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   typedef struct {
      logic       rst_n;
      logic [5:0] cnt;
      logic       fb;
   } vec_t;
   vec_t tv[9];

   initial begin
      int ngv, done_k;
      logic prev_busy;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; golden_ready = 1'b1;
      nonce_first = 0; nonce_last = 0; hash2_in = {32'hDEAD_BEEF, 224'd0};

      tv[0] = '{1'b0, 6'd0, 1'b0};
      tv[1] = '{1'b0, 6'd0, 1'b0};
      tv[2] = '{1'b1, 6'd1, 1'b1};
      tv[3] = '{1'b1, 6'd2, 1'b1};
      tv[4] = '{1'b1, 6'd3, 1'b1};
      tv[5] = '{1'b1, 6'd0, 1'b0};
      tv[6] = '{1'b1, 6'd1, 1'b1};
      tv[7] = '{1'b0, 6'd0, 1'b0};
      tv[8] = '{1'b1, 6'd1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         rst_n = tv[i].rst_n;
         cyc();
         chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tv[i].cnt));
         chk($sformatf("tbl%0d_fb", i), 32'(feedback), 32'(tv[i].fb));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'd0);
         chk($sformatf("tbl%0d_gv", i), 32'(golden_valid), 32'd0);
         chk($sformatf("tbl%0d_gn", i), golden_nonce, 32'd0);
         chk($sformatf("tbl%0d_gl", i), 32'(golden_lost), 32'd0);
         chk($sformatf("tbl%0d_nonce", i), nonce, 32'd0);
      end

      // Range 10..13, golden only on nonce 12.
      policy = 2; target = 12; golden_ready = 1'b1;
      align(); go(10, 13);
      chk("d1_busy", 32'(busy), 32'd1);
      chk("d1_nonce", nonce, 32'd10);
      ngv = 0; done_k = 0; prev_busy = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         cyc();
         if (golden_valid) begin
            ngv++;
            chk("d1_gnonce", golden_nonce, 32'd12);
            chk("d1_g_cycle", k, 32'd24);
         end
         if (done && done_k == 0) begin
            done_k = k;
            chk("d1_busy_fall", {30'd0, prev_busy, busy}, 32'd2);
         end
         prev_busy = busy;
      end
      chk("d1_ngv", ngv, 32'd1);
      chk("d1_done_cycle", done_k, 32'd28);

      // Every slot golden with the consumer stalled, then released.
      policy = 1; golden_ready = 1'b0;
      align(); go(20, 29);
      for (int k = 1; k <= 56; k++) begin
         cyc();
         if (k == 16) begin
            chk("d2_gv16", 32'(golden_valid), 32'd1);
            chk("d2_gn16", golden_nonce, 32'd20);
            chk("d2_gl16", 32'(golden_lost), 32'd0);
         end
         if (k == 20) begin
            chk("d2_gl20", 32'(golden_lost), 32'd1);
            chk("d2_gn20", golden_nonce, 32'd20);
         end
         if (k == 27) begin
            chk("d2_gv27", 32'(golden_valid), 32'd1);
            chk("d2_gn27", golden_nonce, 32'd20);
            golden_ready = 1'b1;
         end
         if (k == 28) begin
            chk("d2_gv28", 32'(golden_valid), 32'd1);
            chk("d2_gn28", golden_nonce, 32'd23);
         end
         if (k == 29) chk("d2_gv29", 32'(golden_valid), 32'd0);
         if (k == 32) begin
            chk("d2_gv32", 32'(golden_valid), 32'd1);
            chk("d2_gn32", golden_nonce, 32'd24);
         end
         if (k == 51) chk("d2_done51", 32'(done), 32'd0);
         if (k == 52) chk("d2_done52", 32'(done), 32'd1);
      end
      chk("d2_gl_end", 32'(golden_lost), 32'd1);

      // Range wrapping through zero; golden on the wrapped nonce.
      policy = 2; target = 0; golden_ready = 1'b1;
      align(); go(32'hFFFF_FFFE, 32'd1);
      chk("d3_gl_cleared", 32'(golden_lost), 32'd0);
      ngv = 0;
      for (int k = 1; k <= 28; k++) begin
         cyc();
         if (k == 3)  chk("d3_n3", nonce, 32'hFFFF_FFFE);
         if (k == 7)  chk("d3_n7", nonce, 32'hFFFF_FFFF);
         if (k == 11) chk("d3_n11", nonce, 32'd0);
         if (k == 15) chk("d3_n15", nonce, 32'd1);
         if (k == 19) chk("d3_n19", nonce, 32'd1);
         if (golden_valid) begin
            ngv++;
            chk("d3_gnonce", golden_nonce, 32'd0);
            chk("d3_g_cycle", k, 32'd24);
         end
      end
      chk("d3_ngv", ngv, 32'd1);
      chk("d3_done", 32'(done), 32'd1);

      // Abort at cnt=2: no further issue, issued hits still reported.
      policy = 1; golden_ready = 1'b1;
      align(); go(100, 199);
      ngv = 0;
      for (int k = 1; k <= 26; k++) begin
         cyc();
         if (k == 13) begin
            chk("d4_cnt13", 32'(cnt), 32'd2);
            abort = 1'b1;
         end
         if (k == 14) abort = 1'b0;
         if (k == 17) begin
            chk("d4_nonce17", nonce, 32'd103);
            chk("d4_busy17", 32'(busy), 32'd1);
         end
         if (golden_valid) begin
            ngv++;
            chk("d4_gnonce", golden_nonce, 32'(100 + (k - 16) / 4));
         end
         if (k == 23) chk("d4_done23", 32'(done), 32'd0);
         if (k == 24) chk("d4_done24", 32'(done), 32'd1);
      end
      chk("d4_ngv", ngv, 32'd3);

      // start during RUN ignored; reset during DRAIN with a pending golden.
      policy = 1; golden_ready = 1'b0;
      align(); go(300, 302);
      for (int k = 1; k <= 18; k++) begin
         cyc();
         if (k == 6) begin start = 1'b1; nonce_first = 500; nonce_last = 600; end
         if (k == 7) begin
            start = 1'b0;
            chk("d5_nonce7", nonce, 32'd301);
         end
         if (k == 9)  chk("d5_nonce9", nonce, 32'd302);
         if (k == 13) chk("d5_busy13", 32'(busy), 32'd1);
         if (k == 16) begin
            chk("d5_gv16", 32'(golden_valid), 32'd1);
            chk("d5_gn16", golden_nonce, 32'd300);
         end
         if (k == 17) rst_n = 1'b0;
         if (k == 18) begin
            chk("d5_rst_cnt", 32'(cnt), 32'd0);
            chk("d5_rst_fb", 32'(feedback), 32'd0);
            chk("d5_rst_nonce", nonce, 32'd0);
            chk("d5_rst_busy", 32'(busy), 32'd0);
            chk("d5_rst_done", 32'(done), 32'd0);
            chk("d5_rst_gv", 32'(golden_valid), 32'd0);
            chk("d5_rst_gn", golden_nonce, 32'd0);
            chk("d5_rst_gl", 32'(golden_lost), 32'd0);
            rst_n = 1'b1;
         end
      end

      // Randomized traffic, checked cycle by cycle against the model.
      policy = 3;
      for (int i = 0; i < 1500; i++) begin
         golden_ready = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 24) == 0);
         abort = ($urandom_range(0, 49) == 0);
         rst_n = ($urandom_range(0, 599) != 0);
         if (start) begin
            nonce_first = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                      : $urandom();
            nonce_last  = nonce_first + 32'($urandom_range(0, 9));
         end
         cyc();
      end
      start = 1'b0; abort = 1'b0; rst_n = 1'b1;
      for (int i = 0; i < 60; i++) cyc();

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
